// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Holds the display-mode encoding, the PWM counter width and the per-mode
// initial pattern loaded whenever the mode changes.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int PWM_W = 8;

  // Widest LED bank the initial-pattern helper can describe.
  localparam int LED_MAX = 32;

  // Pattern shown right after entering a mode; callers truncate to their width.
  function automatic logic [LED_MAX-1:0] init_pattern(input mode_t m);
    case (m)
      MODE_COUNT: init_pattern = '0;
      MODE_BLINK: init_pattern = '1;
      default:    init_pattern = LED_MAX'(1);
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a trailing previous-value flop and edge strobes.
// Latency: an input change sampled at edge N shows on the strobes after edge N+1.
// No backpressure: strobes last exactly one cycle per synchronized transition.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic any_edge,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Shift the asynchronous input through two sync stages and a history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign any_edge = sync ^ prev;
  assign rise     = sync & ~prev;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: blink-toggle edges step a pattern, a button cycles modes.
// Latency: input edge sampled at N updates pattern/mode/step_pulse at N+2.
// No backpressure; enable low drops steps. Optional dimming via `LED_SEQ_PWM_EN.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWM_DUTY = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                mode_btn,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                step_pulse
);

  logic tick_edge;
  logic btn_rise;
  logic unused_tick_rise;
  logic unused_btn_edge;

  sync_edge u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (tick_in),
    .any_edge (tick_edge),
    .rise     (unused_tick_rise)
  );

  sync_edge u_btn_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (mode_btn),
    .any_edge (unused_btn_edge),
    .rise     (btn_rise)
  );

  logic [NUM_LEDS-1:0] pattern;
  mode_t               mode_q;
  logic                dir_up;
  logic                step_q;

  logic                mode_evt;
  logic                step_evt;
  mode_t               mode_nxt;
  logic [NUM_LEDS-1:0] init_val;
  logic [NUM_LEDS-1:0] step_val;
  logic                go_up;

  // A button edge takes priority; a simultaneous step is simply lost.
  assign mode_evt = btn_rise;
  assign step_evt = tick_edge & enable;
  assign mode_nxt = mode_t'(mode_q + 2'd1);
  assign init_val = NUM_LEDS'(init_pattern(mode_nxt));

  // Next pattern for one step in the current mode.
  always_comb begin
    go_up    = dir_up ? ~pattern[NUM_LEDS-1] : pattern[0];
    step_val = pattern;
    case (mode_q)
      MODE_CHASE:  step_val = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
      MODE_BOUNCE: step_val = go_up ? (pattern << 1) : (pattern >> 1);
      MODE_COUNT:  step_val = pattern + NUM_LEDS'(1);
      MODE_BLINK:  step_val = ~pattern;
      default:     step_val = pattern;
    endcase
  end

  // Mode/pattern state machine; the bounce direction is re-decided on each step
  // so the end LED is shown once before turning around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_CHASE;
      pattern <= NUM_LEDS'(1);
      dir_up  <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (mode_evt) begin
        mode_q  <= mode_nxt;
        pattern <= init_val;
        dir_up  <= 1'b1;
      end else if (step_evt) begin
        pattern <= step_val;
        step_q  <= 1'b1;
        if (mode_q == MODE_BOUNCE) begin
          dir_up <= go_up;
        end
      end
    end
  end

  assign mode       = mode_q;
  assign step_pulse = step_q;

`ifdef LED_SEQ_PWM_EN
  localparam logic [PWM_W-1:0] DUTY = PWM_W'(PWM_DUTY);

  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_LEDS-1:0] leds_q;

  // Free-running PWM period counter and gated, registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      leds_q  <= NUM_LEDS'(1) & {NUM_LEDS{DUTY != '0}};
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds_q  <= pattern & {NUM_LEDS{pwm_cnt < DUTY}};
    end
  end

  assign leds = leds_q;
`else
  // Duty setting has no effect without the dimming stage.
  localparam int unused_pwm_duty = PWM_DUTY;

  assign leds = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq against an index/counter based model.
// Directed scenarios for each mode, mode/step collision, enable hold and async
// reset, followed by a randomized mix of ticks, button presses and enable flips.
module tb_led_pattern_seq;

  localparam int N    = 4;
  localparam int DUTY = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_in = 1'b0;
  logic         mode_btn = 1'b0;
  logic         enable = 1'b1;
  logic [N-1:0] leds;
  logic [1:0]   mode;
  logic         step_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: positions and counters, not LED vectors.
  int m_mode;
  int m_pos;
  int m_bidx;
  int m_cnt;
  bit m_blink;

  always #5 clk = ~clk;

  led_pattern_seq #(
    .NUM_LEDS (N),
    .PWM_DUTY (DUTY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .mode_btn   (mode_btn),
    .enable     (enable),
    .leds       (leds),
    .mode       (mode),
    .step_pulse (step_pulse)
  );

  function automatic void model_reset();
    m_mode  = 0;
    m_pos   = 0;
    m_bidx  = 0;
    m_cnt   = 0;
    m_blink = 1'b1;
  endfunction

  function automatic void model_mode();
    m_mode  = (m_mode + 1) % 4;
    m_pos   = 0;
    m_bidx  = 0;
    m_cnt   = 0;
    m_blink = 1'b1;
  endfunction

  function automatic void model_step();
    case (m_mode)
      0:       m_pos = (m_pos + 1) % N;
      1:       m_bidx = (m_bidx + 1) % (2 * N - 2);
      2:       m_cnt = (m_cnt + 1) % (1 << N);
      default: m_blink = ~m_blink;
    endcase
  endfunction

  function automatic logic [N-1:0] model_leds();
    int p;
    logic [N-1:0] r;
    case (m_mode)
      0: r = N'(1 << m_pos);
      1: begin
        p = (m_bidx < N) ? m_bidx : (2 * N - 2 - m_bidx);
        r = N'(1 << p);
      end
      2:       r = N'(m_cnt);
      default: r = m_blink ? '1 : '0;
    endcase
    return r;
  endfunction

  // Toggle tick_in and record leds/step_pulse after edges N+1, N+2 and N+3.
  task automatic tick_observe(output logic [N-1:0] l1, output logic [N-1:0] l2,
                              output logic s1, output logic s2, output logic s3);
    @(negedge clk);
    tick_in = ~tick_in;
    @(negedge clk);
    @(negedge clk);
    l1 = leds;
    s1 = step_pulse;
    @(negedge clk);
    l2 = leds;
    s2 = step_pulse;
    @(negedge clk);
    s3 = step_pulse;
    repeat (5) @(negedge clk);
  endtask

  task automatic press_button();
    @(negedge clk);
    mode_btn = 1'b1;
    repeat (4) @(negedge clk);
    mode_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_leds: got %b expected 0001", leds);
    end
    n_checks++;
    if (mode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mode: got %0d expected 0", mode);
    end
    n_checks++;
    if (step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_step: got %b expected 0", step_pulse);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (leds !== model_leds() || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got leds=%b step=%b expected leds=%b step=0",
               leds, step_pulse, model_leds());
    end
  endtask

  task automatic test_chase();
    logic [N-1:0] l1, l2, prev, exp;
    logic s1, s2, s3;
    for (int i = 0; i < 5; i++) begin
      prev = model_leds();
      model_step();
      exp = model_leds();
      tick_observe(l1, l2, s1, s2, s3);
      n_checks++;
      if (l1 !== prev || s1 !== 1'b0) begin
        n_fail++;
        $display("FAIL chase_early[%0d]: got leds=%b step=%b expected leds=%b step=0",
                 i, l1, s1, prev);
      end
      n_checks++;
      if (l2 !== exp || s2 !== 1'b1) begin
        n_fail++;
        $display("FAIL chase_step[%0d]: got leds=%b step=%b expected leds=%b step=1",
                 i, l2, s2, exp);
      end
      n_checks++;
      if (s3 !== 1'b0) begin
        n_fail++;
        $display("FAIL chase_pulse_width[%0d]: got step=%b expected 0", i, s3);
      end
    end
  endtask

  task automatic test_bounce();
    logic [N-1:0] l1, l2;
    logic s1, s2, s3;
    press_button();
    model_mode();
    n_checks++;
    if (mode !== 2'd1 || leds !== model_leds()) begin
      n_fail++;
      $display("FAIL bounce_enter: got mode=%0d leds=%b expected mode=1 leds=%b",
               mode, leds, model_leds());
    end
    for (int i = 0; i < 7; i++) begin
      model_step();
      tick_observe(l1, l2, s1, s2, s3);
      n_checks++;
      if (l2 !== model_leds() || s2 !== 1'b1) begin
        n_fail++;
        $display("FAIL bounce_step[%0d]: got leds=%b step=%b expected leds=%b step=1",
                 i, l2, s2, model_leds());
      end
    end
  endtask

  task automatic test_count();
    logic [N-1:0] l1, l2;
    logic s1, s2, s3;
    press_button();
    model_mode();
    n_checks++;
    if (mode !== 2'd2 || leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL count_enter: got mode=%0d leds=%b expected mode=2 leds=0000",
               mode, leds);
    end
    for (int i = 0; i < 20; i++) begin
      model_step();
      tick_observe(l1, l2, s1, s2, s3);
      n_checks++;
      if (l2 !== model_leds() || s2 !== 1'b1) begin
        n_fail++;
        $display("FAIL count_step[%0d]: got leds=%b step=%b expected leds=%b step=1",
                 i, l2, s2, model_leds());
      end
    end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (leds !== 4'b0100 || mode !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_pre: got mode=%0d leds=%b expected mode=2 leds=0100",
               mode, leds);
    end
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    tick_in = 1'b0;
    #1;
    n_checks++;
    if (leds !== 4'b0001 || mode !== 2'd0 || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got leds=%b mode=%0d step=%b expected 0001 0 0",
               leds, mode, step_pulse);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (leds !== model_leds() || mode !== 2'd0 || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: got leds=%b mode=%0d step=%b expected %b 0 0",
               leds, mode, step_pulse, model_leds());
    end
  endtask

  task automatic test_collision_enable();
    logic [N-1:0] l1, l2;
    logic s1, s2, s3;
    @(negedge clk);
    mode_btn = 1'b1;
    tick_in  = ~tick_in;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mode !== 2'd0) begin
      n_fail++;
      $display("FAIL collide_early: got mode=%0d expected 0", mode);
    end
    @(negedge clk);
    model_mode();
    n_checks++;
    if (mode !== 2'd1 || leds !== model_leds() || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_mode_wins: got mode=%0d leds=%b step=%b expected 1 %b 0",
               mode, leds, step_pulse, model_leds());
    end
    @(negedge clk);
    n_checks++;
    if (step_pulse !== 1'b0 || leds !== model_leds()) begin
      n_fail++;
      $display("FAIL collide_after: got leds=%b step=%b expected %b 0",
               leds, step_pulse, model_leds());
    end
    mode_btn = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_observe(l1, l2, s1, s2, s3);
      n_checks++;
      if (l2 !== 4'b0001 || s2 !== 1'b0 || s3 !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_hold[%0d]: got leds=%b step=%b,%b expected 0001 0,0",
                 i, l2, s2, s3);
      end
    end
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        @(negedge clk);
        tick_in = ~tick_in;
        repeat (3) @(negedge clk);
        if (enable) model_step();
        n_checks++;
        if (leds !== model_leds() || mode !== 2'(m_mode) || step_pulse !== enable) begin
          n_fail++;
          $display("FAIL rand_tick[%0d]: got leds=%b mode=%0d step=%b expected %b %0d %b",
                   i, leds, mode, step_pulse, model_leds(), m_mode, enable);
        end
      end else if (op == 3) begin
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (3) @(negedge clk);
        model_mode();
        n_checks++;
        if (leds !== model_leds() || mode !== 2'(m_mode) || step_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_mode[%0d]: got leds=%b mode=%0d step=%b expected %b %0d 0",
                   i, leds, mode, step_pulse, model_leds(), m_mode);
        end
        mode_btn = 1'b0;
        repeat (2) @(negedge clk);
      end else if (op == 4) begin
        @(negedge clk);
        enable = ~enable;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    enable = 1'b1;
  endtask

  task automatic test_pwm();
    int on_cnt;
    bit hi_bad;
    for (int w = 0; w < 4; w++) begin
      on_cnt = 0;
      hi_bad = 1'b0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk);
        if (leds[0] === 1'b1) on_cnt++;
        if (leds[N-1:1] !== '0) hi_bad = 1'b1;
      end
      n_checks++;
      if (on_cnt != DUTY) begin
        n_fail++;
        $display("FAIL pwm_duty[%0d]: got %0d on-cycles expected %0d", w, on_cnt, DUTY);
      end
      n_checks++;
      if (hi_bad) begin
        n_fail++;
        $display("FAIL pwm_upper_dark[%0d]: got lit upper LEDs expected none", w);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef LED_SEQ_PWM_EN
    test_pwm();
`else
    test_chase();
    test_bounce();
    test_count();
    test_async_reset();
    test_collision_enable();
    test_random();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Downstream consumer of the slow blink toggle produced by the board's clock-divider blinker. Each edge of that toggle advances an LED pattern state machine. A push button cycles the block through four display modes. The block drives the board LEDs directly. An optional PWM stage dims them.

## Interface
- NUM_LEDS, 4, LED count; legal range ≥ 2.
- PWM_DUTY, 64, on-time per 256-cycle PWM period; legal range 0..255; used only when PWM is compiled in.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_in  in  1  blink toggle from the divider; treated as asynchronous; every edge (rising or falling) is one step.
- mode_btn  in  1  push button, asynchronous, active-high; each synchronized rising edge advances the mode.
- enable  in  1  step enable; low freezes the pattern.
- leds  out  NUM_LEDS  LED drive, registered.
- mode  out  2  current mode.
- step_pulse  out  1  one-cycle strobe on each applied pattern step.

## Operation
- tick_in and mode_btn each pass through a 2-flop synchronizer, reset 0. A previous-value flop follows each synchronizer.
- Step event: synchronized tick differs from its previous value.
- Mode event: synchronized button is 1 and its previous value is 0.
- Modes:
  - 0 CHASE: one-hot rotate toward MSB; MSB wraps to bit 0.
  - 1 BOUNCE: one-hot with a direction flag. At the MSB the direction flips to down; at bit 0 it flips to up. The end position is shown once, with no repeat.
  - 2 COUNT: binary up-count modulo 2^NUM_LEDS; all-ones wraps to 0.
  - 3 BLINK: all LEDs invert together.
- Mode event: mode ← mode+1, with 3 wrapping to 0. The pattern loads the new mode's initial value:
  - CHASE: 1.
  - BOUNCE: 1, direction up.
  - COUNT: 0.
  - BLINK: all ones.
- A mode event and a step event in the same cycle: the mode event wins, the step is dropped and step_pulse stays 0.
- enable=0: step events are ignored and the pattern is held. Mode events are still applied.
- Reset values (asynchronous):
  - pattern = 1 (led[0] on).
  - mode = 0.
  - direction = up.
  - step_pulse = 0.
  - all synchronizer and previous-value flops = 0.
  - PWM counter = 0.

## Timing
- A tick_in transition sampled at edge N reaches the second sync flop at N+1. The pattern and step_pulse update at N+2.
- step_pulse is high for exactly the cycle after N+2.
- Mode path latency is identical: the button edge sampled at N gives the new mode and pattern at N+2.
- tick_in edges closer than 3 clk cycles apart are not guaranteed to be resolved. In the intended use they are seconds apart.
- leds and mode are registered and carry no combinational path from the inputs.

## Configuration
- LED_SEQ_PWM_EN defined:
  - An 8-bit free-running counter runs from reset value 0 and wraps 255→0.
  - leds = pattern AND (pwm_cnt < PWM_DUTY), replicated across all bits and registered.
  - PWM_DUTY=0 gives all LEDs dark.
  - PWM_DUTY=255 gives 255 on-cycles per 256.
- LED_SEQ_PWM_EN undefined: leds = pattern, no PWM counter exists, PWM_DUTY is ignored.

## Structure
- Package led_seq_pkg holds:
  - mode typedef (2-bit enum): MODE_CHASE=0, MODE_BOUNCE=1, MODE_COUNT=2, MODE_BLINK=3.
  - PWM_W=8.
  - per-mode initial-pattern function.
- One sub-module, sync_edge: 2-flop synchronizer plus previous-value flop. It outputs both any-edge and rising-edge strobes and is instantiated twice (tick_in, mode_btn).

## Test plan
1. Async reset: with the pattern at 0100 in COUNT mode, drop rst_n mid-cycle. leds=0001, mode=0, step_pulse=0 must appear immediately, without waiting for a clk edge.
2. CHASE, NUM_LEDS=4, five tick_in toggles spaced 10 cycles apart. Required: leds 0010, 0100, 1000, 0001, 0010, each change 2 cycles after sampling, with one step_pulse per toggle.
3. BOUNCE, seven toggles. Required: 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. COUNT, seventeen toggles. Required: 0001 through 1111, then 0000, then 0001 (wrap).
5. Button rising edge and tick_in edge synchronized in the same cycle while in CHASE. Required: mode=1, leds=0001, step_pulse=0. Then enable=0 with 3 toggles: leds hold at 0001 and step_pulse stays 0.
6. LED_SEQ_PWM_EN, PWM_DUTY=64, pattern 0001. Required: led[0] high for exactly 64 of every 256 consecutive cycles, led[3:1] constantly 0.
